memory_arbiter: RTL and testbench

Two-requester arbiter that shares one memory port between the instruction-fetch path and the load/store path of the multi-cycle core. The memory port may stall, so the block holds each granted transfer, waits for `memory_ready`, returns read data to the owning requester with a one-cycle acknowledge, and aborts transfers that exceed a wait limit. It sits between the core's fetch and load/store logic and the unified `DataMemory`-style port.

---
 rtl/memory_arbiter_pkg.sv | 25 ++
 rtl/memory_arbiter_wait_timer.sv | 27 ++
 rtl/memory_arbiter.sv | 127 ++++++++++++
 tb/tb_memory_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the fetch / load-store memory arbiter.
// Size codes match the core's load/store unit.
package memory_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // A lone request wins; on a tie the port not granted last time wins.
  function automatic logic arb_pick(input logic i_req, input logic d_req, input logic last);
    if (i_req && d_req) return (last == ARB_OWNER_D) ? ARB_OWNER_I : ARB_OWNER_D;
    if (d_req)          return ARB_OWNER_D;
    return ARB_OWNER_I;
  endfunction

endpackage

// File: rtl/memory_arbiter_wait_timer.sv
// Wait counter for a stalled memory access; expired is high once the
// count reaches MAX_WAIT and the count then holds.
module arb_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + 1'b1;
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one stallable memory port between instruction fetch and load/store,
// holding each granted transfer until ready or wait-limit abort.
//
// state | meaning
// IDLE  | no transfer; grant a pending request and latch its fields
// BUSY  | memory_require high, waiting for memory_ready or timeout
// RESP  | one-cycle ack to the owner, requests not sampled
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  memory_require,
  output logic                  memory_write_enable,
  output logic [2:0]            memory_size,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  input  logic                  memory_ready
);

  logic [1:0]            state;
  logic                  owner;
  logic                  last;
  logic                  we_q;
  logic [2:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  grant;
  logic                  expired;

  assign grant = arb_pick(i_req, d_req, last);

  arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ARB_BUSY),
    .enable  (state == ARB_BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= ARB_OWNER_I;
      last      <= ARB_OWNER_D;
      we_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_req || d_req) begin
            owner <= grant;
            last  <= grant;
            state <= ARB_BUSY;
            if (grant == ARB_OWNER_I) begin
              we_q    <= 1'b0;
              size_q  <= LDST_W;
              addr_q  <= i_addr;
              wdata_q <= '0;
            end else begin
              we_q    <= d_we;
              size_q  <= d_size;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end
          end
        end
        ARB_BUSY: begin
          // Ready wins over expiry when both land on the same cycle.
          if (memory_ready) begin
            err_q <= 1'b0;
            state <= ARB_RESP;
            if (owner == ARB_OWNER_I) i_rdata_q <= memory_read_data;
            else                      d_rdata_q <= we_q ? '0 : memory_read_data;
          end else if (expired) begin
            err_q <= 1'b1;
            state <= ARB_RESP;
            if (owner == ARB_OWNER_I) i_rdata_q <= '0;
            else                      d_rdata_q <= '0;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  assign memory_require      = (state == ARB_BUSY);
  assign memory_write_enable = memory_require && we_q;
  assign memory_size         = size_q;
  assign memory_address      = addr_q;
  assign memory_write_data   = wdata_q;

  assign i_ack   = (state == ARB_RESP) && (owner == ARB_OWNER_I);
  assign d_ack   = (state == ARB_RESP) && (owner == ARB_OWNER_D);
  assign i_err   = i_ack && err_q;
  assign d_err   = d_ack && err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected acks into a
// scoreboard queue; a negedge monitor pops and compares on every ack.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 15;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [2:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          memory_require;
  logic          memory_write_enable;
  logic [2:0]    memory_size;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] memory_write_data;
  logic [DW-1:0] memory_read_data;
  logic          memory_ready;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_req               (i_req),
    .i_addr              (i_addr),
    .i_ack               (i_ack),
    .i_rdata             (i_rdata),
    .i_err               (i_err),
    .d_req               (d_req),
    .d_we                (d_we),
    .d_size              (d_size),
    .d_addr              (d_addr),
    .d_wdata             (d_wdata),
    .d_ack               (d_ack),
    .d_rdata             (d_rdata),
    .d_err               (d_err),
    .memory_require      (memory_require),
    .memory_write_enable (memory_write_enable),
    .memory_size         (memory_size),
    .memory_address      (memory_address),
    .memory_write_data   (memory_write_data),
    .memory_read_data    (memory_read_data),
    .memory_ready        (memory_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_require"}, memory_require, 0);
    check({tag, "_we"},      memory_write_enable, 0);
    check({tag, "_size"},    memory_size, 0);
    check({tag, "_addr"},    memory_address, 0);
    check({tag, "_wdata"},   memory_write_data, 0);
    check({tag, "_acks"},    {i_ack, d_ack, i_err, d_err}, 0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (i_ack || d_ack)) begin
      exp_t e;
      check("ack_exclusive", i_ack && d_ack, 0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        check("ack_port", d_ack, e.port);
        if (e.port == ARB_OWNER_I) begin
          check("i_rdata", i_rdata, e.rdata);
          check("i_err",   i_err,   e.err);
          check("d_err_idle", d_err, 0);
        end else begin
          check("d_rdata", d_rdata, e.rdata);
          check("d_err",   d_err,   e.err);
          check("i_err_idle", i_err, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = '0; d_addr = '0; d_wdata = '0; memory_read_data = '0; memory_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait fetch
    i_req = 1'b1; i_addr = 32'h10; memory_ready = 1'b1; memory_read_data = 32'hDEADBEEF;
    sb.push_back('{ARB_OWNER_I, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    check("f_require_c1", memory_require, 1);
    check("f_addr_c1", memory_address, 32'h10);
    check("f_size_c1", memory_size, LDST_W);
    check("f_we_c1", memory_write_enable, 0);
    check("f_iack_c1", i_ack, 0);
    @(negedge clk);
    check("f_iack_c2", i_ack, 1);
    check("f_require_c2", memory_require, 0);
    i_req = 1'b0;
    @(negedge clk);
    check("f_idle_c3", {memory_require, i_ack}, 0);

    // Store with 3 wait cycles; req dropped early must not cancel it
    d_req = 1'b1; d_we = 1'b1; d_size = LDST_B; d_addr = 32'h104; d_wdata = 32'hAB;
    memory_ready = 1'b0; memory_read_data = 32'h12345678;
    sb.push_back('{ARB_OWNER_D, 32'h0, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("s_require", memory_require, 1);
      check("s_we", memory_write_enable, 1);
      check("s_addr", memory_address, 32'h104);
      check("s_wdata", memory_write_data, 32'hAB);
      check("s_size", memory_size, LDST_B);
      check("s_dack_early", d_ack, 0);
      if (c == 1) d_req = 1'b0;
      if (c == 4) memory_ready = 1'b1;
    end
    @(negedge clk);
    check("s_dack_c5", d_ack, 1);
    check("s_iack_c5", i_ack, 0);
    check("s_we_resp", memory_write_enable, 0);
    memory_ready = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("s_idle", {memory_require, d_ack}, 0);

    // Both requesting, zero-wait: order I, D, I, D
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300; d_size = LDST_H;
    memory_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      sb.push_back('{((k % 2) == 1), 32'hC0DE_0000 + k, 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_require", memory_require, 1);
      check("rr_addr", memory_address, (k % 2 == 0) ? 32'h200 : 32'h300);
      check("rr_size", memory_size, (k % 2 == 0) ? LDST_W : LDST_H);
      memory_read_data = 32'hC0DE_0000 + k;
      if (k == 3) begin i_req = 1'b0; d_req = 1'b0; end
      @(negedge clk);
      check("rr_ack", {i_ack, d_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge clk);
      check("rr_gap", {memory_require, i_ack, d_ack}, 0);
    end
    memory_ready = 1'b0;

    // Timeout: ack with err exactly MAX_WAIT+2 cycles after grant
    d_req = 1'b1; d_addr = 32'h400; memory_read_data = 32'hFFFF0000;
    sb.push_back('{ARB_OWNER_D, 32'h0, 1'b1});
    for (int c = 1; c <= MW + 1; c++) begin
      @(negedge clk);
      check("to_require", memory_require, 1);
      check("to_no_ack", d_ack, 0);
      if (c == 1) d_req = 1'b0;
    end
    @(negedge clk);
    check("to_dack", d_ack, 1);
    check("to_require_resp", memory_require, 0);
    @(negedge clk);
    check("to_idle", {memory_require, d_ack}, 0);

    // Ready on the expiry cycle wins
    i_req = 1'b1; i_addr = 32'h500;
    sb.push_back('{ARB_OWNER_I, 32'h5A5A5A5A, 1'b0});
    for (int c = 1; c <= MW + 1; c++) begin
      @(negedge clk);
      check("ex_no_ack", i_ack, 0);
      if (c == 1) i_req = 1'b0;
      if (c == MW + 1) begin memory_ready = 1'b1; memory_read_data = 32'h5A5A5A5A; end
    end
    @(negedge clk);
    check("ex_iack", i_ack, 1);
    memory_ready = 1'b0;
    @(negedge clk);

    // Reset during BUSY drops the transfer; last returns to D so I wins the tie
    i_req = 1'b1; i_addr = 32'h600;
    @(negedge clk);
    check("rb_require_c1", memory_require, 1);
    @(negedge clk);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    check_all_zero("rb_after");
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h700; d_req = 1'b1; d_addr = 32'h800; d_we = 1'b0;
    memory_ready = 1'b1; memory_read_data = 32'h77;
    sb.push_back('{ARB_OWNER_I, 32'h77, 1'b0});
    @(negedge clk);
    check("rb_tie_addr", memory_address, 32'h700);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("rb_iack", {i_ack, d_ack}, 2'b10);
    @(negedge clk);
    memory_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
